// File: rtl/rv32i_types.sv
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared types for the cache/memory subsystem. Holds the
//                cacheline arbiter FSM state and client identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    // Width of a physical memory line address.
    localparam int C_PMEM_ADDR_W = 32;

    // Arbiter FSM state; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    // Arbitration winner.
    typedef enum logic {
        ARB_CLIENT_I = 1'b0,
        ARB_CLIENT_D = 1'b1
    } arb_client_t;

endpackage : rv32i_types

`default_nettype wire

// File: rtl/cacheline_arbiter_priority.sv
// ============================================================================
//  Module      : arb_priority
//  Description : Winner selection between the I- and D-cache clients plus
//                the D-grant streak counter that prevents I starvation.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_req, d_req  - client request levels
//                grant_en      - a grant is being made this cycle
//                winner        - combinational winner for this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_priority
    import rv32i_types::*;
#(
    parameter int MAX_D_STREAK = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        d_req,
    input  logic        grant_en,
    output arb_client_t winner
);

    localparam int C_STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [C_STREAK_W-1:0] C_STREAK_MAX = C_STREAK_W'(MAX_D_STREAK);
    localparam logic [C_STREAK_W-1:0] C_STREAK_ONE = C_STREAK_W'(1);

    logic [C_STREAK_W-1:0] r_streak;

    // D is preferred; I wins when alone or once D has used up its streak.
    always_comb begin
        winner = ARB_CLIENT_D;
        if (i_req && !d_req) begin
            winner = ARB_CLIENT_I;
        end else if (i_req && d_req && (r_streak == C_STREAK_MAX)) begin
            winner = ARB_CLIENT_I;
        end
    end

    // The streak only grows for D grants that made I wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (grant_en) begin
            if (winner == ARB_CLIENT_I) begin
                r_streak <= '0;
            end else if (i_req) begin
                if (r_streak != C_STREAK_MAX) begin
                    r_streak <= r_streak + C_STREAK_ONE;
                end
            end else begin
                r_streak <= '0;
            end
        end
    end

endmodule : arb_priority

`default_nettype wire

// File: rtl/cacheline_arbiter.sv
// ============================================================================
//  Module      : cacheline_arbiter
//  Description : Shares the single physical-memory line port between the
//                I-cache and D-cache. Latches the winning request, drives it
//                to memory from registers and steers the response and read
//                line back to the granted client only.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                i_pmem_*                 - I-cache client port
//                d_pmem_*                 - D-cache client port
//                pmem_*                   - physical memory port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_arbiter
    import rv32i_types::*;
#(
    parameter int WIDTH        = 256,
    parameter int MAX_D_STREAK = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             i_pmem_read,
    input  logic             i_pmem_write,
    input  logic [31:0]      i_pmem_address,
    input  logic [WIDTH-1:0] i_pmem_wdata,
    output logic             i_pmem_resp,
    output logic [WIDTH-1:0] i_pmem_rdata,

    input  logic             d_pmem_read,
    input  logic             d_pmem_write,
    input  logic [31:0]      d_pmem_address,
    input  logic [WIDTH-1:0] d_pmem_wdata,
    output logic             d_pmem_resp,
    output logic [WIDTH-1:0] d_pmem_rdata,

    output logic             pmem_read,
    output logic             pmem_write,
    output logic [31:0]      pmem_address,
    output logic [WIDTH-1:0] pmem_wdata,
    input  logic [WIDTH-1:0] pmem_rdata,
    input  logic             pmem_resp
);

    arb_state_t         r_state;
    logic               r_pmem_read;
    logic               r_pmem_write;
    logic [31:0]        r_addr;
    logic [WIDTH-1:0]   r_wdata;

    logic               w_i_req;
    logic               w_d_req;
    logic               w_grant_en;
    arb_client_t        w_winner;

    logic               w_sel_write;
    logic [31:0]        w_sel_addr;
    logic [WIDTH-1:0]   w_sel_wdata;

    assign w_i_req    = i_pmem_read | i_pmem_write;
    assign w_d_req    = d_pmem_read | d_pmem_write;
    assign w_grant_en = (r_state == ARB_IDLE) && (w_i_req || w_d_req);

    arb_priority #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_priority (
        .clk      (clk),
        .rst      (rst),
        .i_req    (w_i_req),
        .d_req    (w_d_req),
        .grant_en (w_grant_en),
        .winner   (w_winner)
    );

    // Fields of the winning client, ready to be latched on a grant.
    always_comb begin
        w_sel_write = d_pmem_write;
        w_sel_addr  = d_pmem_address;
        w_sel_wdata = d_pmem_wdata;
        if (w_winner == ARB_CLIENT_I) begin
            w_sel_write = i_pmem_write;
            w_sel_addr  = i_pmem_address;
            w_sel_wdata = i_pmem_wdata;
        end
    end

    // Strobes are registered so memory never sees combinational glitches;
    // a set write strobe overrides a simultaneous read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_en) begin
                        r_state      <= (w_winner == ARB_CLIENT_I) ? ARB_BUSY_I : ARB_BUSY_D;
                        r_pmem_write <= w_sel_write;
                        r_pmem_read  <= ~w_sel_write;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                    end
                end
                ARB_BUSY_I, ARB_BUSY_D: begin
                    if (pmem_resp) begin
                        r_state      <= ARB_IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ARB_IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;

    // Response steering is combinational so the client sees resp in the
    // same cycle as memory; the idle state swallows stray memory resps.
    assign i_pmem_resp  = (r_state == ARB_BUSY_I) && pmem_resp;
    assign d_pmem_resp  = (r_state == ARB_BUSY_D) && pmem_resp;
    assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
    assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

endmodule : cacheline_arbiter

`default_nettype wire

// File: tb/tb_cacheline_arbiter.sv
// ============================================================================
//  Module      : tb_cacheline_arbiter
//  Description : Self-checking bench for cacheline_arbiter. Directed
//                scenarios followed by random traffic, all compared against
//                a transaction-level reference model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cacheline_arbiter;

    localparam int W    = 256;
    localparam int MAXS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
    logic [31:0]   i_pmem_address, d_pmem_address;
    logic [W-1:0]  i_pmem_wdata, d_pmem_wdata;
    logic          i_pmem_resp, d_pmem_resp;
    logic [W-1:0]  i_pmem_rdata, d_pmem_rdata;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [31:0]   pmem_address;
    logic [W-1:0]  pmem_wdata, pmem_rdata;

    always #5 clk = ~clk;

    cacheline_arbiter #(.WIDTH(W), .MAX_D_STREAK(MAXS)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_write   (i_pmem_write),
        .i_pmem_address (i_pmem_address),
        .i_pmem_wdata   (i_pmem_wdata),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns memory (0 none, 1 I, 2 D), the latched
    // request and the count of D grants that made I wait.
    int           m_owner;
    logic         m_wr;
    logic [31:0]  m_addr;
    logic [W-1:0] m_wdata;
    int           m_streak;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_line();
        logic [W-1:0] v;
        for (int j = 0; j < W / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    // Mid-cycle compare of every output against the model.
    task automatic eval();
        logic e_busy, e_ir, e_dr;
        @(negedge clk);
        e_busy = (m_owner != 0);
        e_ir   = (m_owner == 1) && pmem_resp;
        e_dr   = (m_owner == 2) && pmem_resp;
        chk("pmem_read",    W'(pmem_read),    W'(e_busy && !m_wr));
        chk("pmem_write",   W'(pmem_write),   W'(e_busy && m_wr));
        chk("pmem_address", W'(pmem_address), W'(m_addr));
        chk("pmem_wdata",   pmem_wdata,       m_wdata);
        chk("i_pmem_resp",  W'(i_pmem_resp),  W'(e_ir));
        chk("d_pmem_resp",  W'(d_pmem_resp),  W'(e_dr));
        chk("i_pmem_rdata", i_pmem_rdata,     e_ir ? pmem_rdata : '0);
        chk("d_pmem_rdata", d_pmem_rdata,     e_dr ? pmem_rdata : '0);
    endtask

    // Clock edge: advance the model with the inputs seen at the edge.
    task automatic adv();
        logic ir, dr, win_i;
        @(posedge clk);
        ir = i_pmem_read | i_pmem_write;
        dr = d_pmem_read | d_pmem_write;
        if (rst) begin
            m_owner = 0; m_streak = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        end else if (m_owner != 0) begin
            if (pmem_resp) m_owner = 0;
        end else if (ir || dr) begin
            win_i = ir && (!dr || m_streak == MAXS);
            if (win_i) begin
                m_owner = 1; m_wr = i_pmem_write; m_addr = i_pmem_address;
                m_wdata = i_pmem_wdata; m_streak = 0;
            end else begin
                m_owner = 2; m_wr = d_pmem_write; m_addr = d_pmem_address;
                m_wdata = d_pmem_wdata;
                m_streak = ir ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
            end
        end
        #1;
    endtask

    task automatic set_i(input logic rd, input logic wr, input logic [31:0] a, input logic [W-1:0] wd);
        i_pmem_read = rd; i_pmem_write = wr; i_pmem_address = a; i_pmem_wdata = wd;
    endtask

    task automatic set_d(input logic rd, input logic wr, input logic [31:0] a, input logic [W-1:0] wd);
        d_pmem_read = rd; d_pmem_write = wr; d_pmem_address = a; d_pmem_wdata = wd;
    endtask

    initial begin
        logic [W-1:0] line;
        int           got;
        int           exp_order [5] = '{2, 2, 1, 2, 2};

        rst = 1'b1;
        set_i(1'b0, 1'b0, '0, '0);
        set_d(1'b0, 1'b0, '0, '0);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        m_owner = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_streak = 0;
        adv();

        // Reset state: every output zero.
        eval();
        chk("rst_pmem_read",    W'(pmem_read),    '0);
        chk("rst_pmem_write",   W'(pmem_write),   '0);
        chk("rst_pmem_address", W'(pmem_address), '0);
        chk("rst_i_resp",       W'(i_pmem_resp),  '0);
        adv();
        rst = 1'b0;

        // I read alone at 0x1000, memory answers in cycle 4.
        line = rnd_line();
        pmem_rdata = line;
        set_i(1'b1, 1'b0, 32'h0000_1000, '0);
        eval(); adv();
        for (int c = 1; c <= 4; c++) begin
            pmem_resp = (c == 4);
            eval();
            chk("i_rd_strobe", W'(pmem_read), W'(1'b1));
            chk("i_rd_addr",   W'(pmem_address), W'(32'h0000_1000));
            if (c == 4) begin
                chk("i_rd_resp",  W'(i_pmem_resp), W'(1'b1));
                chk("i_rd_line",  i_pmem_rdata, line);
                chk("i_rd_dresp", W'(d_pmem_resp), '0);
            end
            adv();
        end
        set_i(1'b0, 1'b0, '0, '0);
        pmem_resp = 1'b0;
        eval();
        chk("i_rd_done_strobe", W'(pmem_read), '0);
        adv();

        // D write at 0x8000_0040 with 0xA5 pattern.
        set_d(1'b0, 1'b1, 32'h8000_0040, {32{8'hA5}});
        eval(); adv();
        pmem_resp = 1'b1;
        eval();
        chk("d_wr_strobe", W'(pmem_write), W'(1'b1));
        chk("d_wr_noread", W'(pmem_read), '0);
        chk("d_wr_addr",   W'(pmem_address), W'(32'h8000_0040));
        chk("d_wr_data",   pmem_wdata, {32{8'hA5}});
        chk("d_wr_resp",   W'(d_pmem_resp), W'(1'b1));
        adv();
        set_d(1'b0, 1'b0, '0, '0);
        pmem_resp = 1'b0;
        eval(); adv();

        // Simultaneous reads: D first, I strobes at resp+2.
        set_i(1'b1, 1'b0, 32'h0000_0100, '0);
        set_d(1'b1, 1'b0, 32'h0000_0200, '0);
        eval(); adv();
        eval();
        chk("sim_d_first", W'(pmem_address), W'(32'h0000_0200));
        adv();
        pmem_resp = 1'b1;
        eval();
        chk("sim_d_resp",  W'(d_pmem_resp), W'(1'b1));
        chk("sim_i_quiet", W'(i_pmem_resp), '0);
        adv();
        set_d(1'b0, 1'b0, '0, '0);
        pmem_resp = 1'b0;
        eval();
        chk("sim_gap", W'(pmem_read), '0);
        adv();
        pmem_resp = 1'b1;
        eval();
        chk("sim_i_strobe", W'(pmem_read), W'(1'b1));
        chk("sim_i_addr",   W'(pmem_address), W'(32'h0000_0100));
        chk("sim_i_resp",   W'(i_pmem_resp), W'(1'b1));
        chk("sim_d_quiet",  W'(d_pmem_resp), '0);
        adv();
        set_i(1'b0, 1'b0, '0, '0);
        pmem_resp = 1'b0;
        eval(); adv();

        // Both held: grant order D, D, I, D, D.
        set_i(1'b1, 1'b0, 32'h0000_0500, '0);
        set_d(1'b1, 1'b0, 32'h0000_0600, '0);
        for (int k = 0; k < 5; k++) begin
            pmem_resp = 1'b0;
            eval(); adv();
            pmem_resp = 1'b1;
            eval();
            got = i_pmem_resp ? 1 : (d_pmem_resp ? 2 : 0);
            chk($sformatf("streak_grant%0d", k), W'(got), W'(exp_order[k]));
            adv();
        end
        set_i(1'b0, 1'b0, '0, '0);
        set_d(1'b0, 1'b0, '0, '0);
        pmem_resp = 1'b0;
        eval(); adv();

        // Client address changes mid-transaction are ignored.
        set_i(1'b1, 1'b0, 32'h0000_3000, '0);
        eval(); adv();
        set_i(1'b1, 1'b0, 32'hDEAD_BEE0, '0);
        eval();
        chk("hold_addr", W'(pmem_address), W'(32'h0000_3000));
        adv();
        pmem_resp = 1'b1;
        eval();
        chk("hold_addr_resp", W'(pmem_address), W'(32'h0000_3000));
        adv();
        set_i(1'b0, 1'b0, '0, '0);
        pmem_resp = 1'b0;
        eval(); adv();

        // Reset two cycles into a D read; stray memory resp afterwards.
        set_d(1'b1, 1'b0, 32'h0000_4000, '0);
        eval(); adv();
        eval(); adv();
        rst = 1'b1;
        eval(); adv();
        rst = 1'b0;
        set_d(1'b0, 1'b0, '0, '0);
        pmem_resp = 1'b1;
        eval();
        chk("mrst_read",  W'(pmem_read), '0);
        chk("mrst_addr",  W'(pmem_address), '0);
        chk("mrst_dresp", W'(d_pmem_resp), '0);
        chk("mrst_iresp", W'(i_pmem_resp), '0);
        adv();
        pmem_resp = 1'b0;
        set_i(1'b1, 1'b0, 32'h0000_7000, '0);
        eval(); adv();
        pmem_resp = 1'b1;
        eval();
        chk("post_rst_strobe", W'(pmem_read), W'(1'b1));
        chk("post_rst_addr",   W'(pmem_address), W'(32'h0000_7000));
        chk("post_rst_resp",   W'(i_pmem_resp), W'(1'b1));
        adv();
        set_i(1'b0, 1'b0, '0, '0);
        pmem_resp = 1'b0;
        eval(); adv();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            set_i(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), $urandom, rnd_line());
            set_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), $urandom, rnd_line());
            pmem_resp  = ($urandom_range(0, 2) == 0);
            pmem_rdata = rnd_line();
            eval();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cacheline_arbiter

`default_nettype wire
